// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master (CPOL=0, CPHA=0) with 8-bit frames and
// multi-byte bursts (cs held low between bytes). Everything runs on sysClk.
// Optional build macro SPI_LSB_FIRST_EN: frames go LSB first instead of MSB first.
//
// Handshake: a byte is accepted on any sysClk edge where start=1 and ready=1;
// tx_byte and last are captured on that edge only. rx_valid is a one-cycle
// pulse on the edge rx_byte takes the newly received byte.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       last,
  output logic       ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       spiClk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  localparam int CW = 16;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_next;
  logic [7:0]    tx_shifted;
  logic          last_q;
  logic [1:0]    miso_ff;
  logic          miso_sync;
  logic          accept;
  logic          setup_done, div_done, hold_done;
  logic          bit_done, byte_done;

  assign miso_sync  = miso_ff[1];
  assign accept     = start && ready;
  assign setup_done = (cnt == CW'(CS_SETUP - 1));
  assign div_done   = (cnt == CW'(CLK_DIV - 1));
  assign hold_done  = (cnt == CW'(CS_HOLD - 1));
  assign bit_done   = (state == S_HI) && div_done;
  assign byte_done  = bit_done && (bit_cnt == 3'd7);

  // mosi is the outgoing end of the tx shift register, so it is a flop output
  // and changes only on load or on the edge where spiClk falls.
`ifdef SPI_LSB_FIRST_EN
  assign mosi       = tx_sh[0];
  assign tx_shifted = {1'b0, tx_sh[7:1]};
  assign rx_next    = {miso_sync, rx_sh};
`else
  assign mosi       = tx_sh[7];
  assign tx_shifted = {tx_sh[6:0], 1'b0};
  assign rx_next    = {rx_sh, miso_sync};
`endif

  // Two-flop synchronizer for the asynchronous miso pin
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) miso_ff <= 2'b00;
    else       miso_ff <= {miso_ff[0], miso};
  end

  // State register with a phase counter that restarts on every state change
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic: frame sequencing and half-period timing
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: if (setup_done) state_next = S_LO;
      S_LO:    if (div_done) state_next = S_HI;
      S_HI: begin
        if (div_done) begin
          if (bit_cnt == 3'd7) state_next = last_q ? S_HOLD : S_WAIT;
          else                 state_next = S_LO;
        end
      end
      S_WAIT:  if (start) state_next = S_LO;
      S_HOLD:  if (hold_done) state_next = S_GAP;
      S_GAP:   if (hold_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    ready     = (state == S_IDLE) || (state == S_WAIT);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  // Pin registers: cs and spiClk are registered from the next state so they
  // are glitch-free and change on the same edge as the state itself
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      cs     <= 1'b1;
      spiClk <= 1'b0;
    end else begin
      cs     <= (state_next == S_IDLE) || (state_next == S_GAP);
      spiClk <= (state_next == S_HI);
    end
  end

  // Shift datapath: load on accept, sample at the end of each high phase
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        tx_sh   <= tx_byte;
        last_q  <= last;
        bit_cnt <= '0;
      end else if (bit_done) begin
        bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_LSB_FIRST_EN
        rx_sh   <= rx_next[7:1];
`else
        rx_sh   <= rx_next[6:0];
`endif
        // Keep the last bit on mosi after the byte; the next load replaces it
        if (!byte_done) tx_sh <= tx_shifted;
        if (byte_done) begin
          rx_byte  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master. A behavioural SPI slave
// answers each frame; expected bytes and edge timing are queued when a byte
// is issued and checked by a monitor when the DUT shows the event.
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       sysClk  = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       last    = 1'b0;
  logic       miso    = 1'b0;
  logic       ready, rx_valid, busy, spiClk, cs, mosi;
  logic [7:0] rx_byte;
  logic [2:0] state_dbg;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .sysClk(sysClk), .reset(reset), .start(start), .tx_byte(tx_byte), .last(last),
    .ready(ready), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .spiClk(spiClk), .cs(cs), .mosi(mosi), .miso(miso), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 sysClk = ~sysClk;

  int ncyc = 0;
  always @(posedge sysClk) ncyc <= ncyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, ncyc=%0d", ncyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];   // expected rx bytes (what the slave sends)
  logic [7:0] tx_q[$];    // expected bytes seen on mosi
  logic [7:0] sl_q[$];    // bytes the slave will answer with
  int         rise_q[$];  // expected cycle of each byte's first spiClk rise

  logic [7:0] b_tx[4];
  logic [7:0] b_sl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Bit i of a frame in wire order
  function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
    return b[3'(i)];
`else
    return b[3'(7 - i)];
`endif
  endfunction

  // ---------------- slave model + monitor ----------------
  logic [7:0] sl_cur = 8'h00;
  logic [7:0] mo_byte = 8'h00;
  int         sl_bit = 0, mo_bits = 0;
  int         first_rise = 0, last_valid = 0, cs_rise = 0;
  logic       cs_p = 1'b1, sck_p = 1'b0, rdy_p = 1'b1;

  task automatic slave_load();
    if (sl_q.size() > 0) sl_cur = sl_q.pop_front();
    else                 sl_cur = 8'h00;
    sl_bit = 0;
    miso   = wire_bit(sl_cur, 0);
  endtask

  always @(negedge sysClk) begin
    if (reset) begin
      cs_p = 1'b1; sck_p = 1'b0; rdy_p = 1'b1;
      sl_bit = 0; mo_bits = 0; miso = 1'b0;
    end else begin
      // cs falling: slave puts its first bit out before the first rise
      if (cs_p && !cs) slave_load();
      // spiClk falling: slave shifts out its next bit
      if (!cs && sck_p && !spiClk) begin
        sl_bit++;
        if (sl_bit == 8) slave_load();
        else             miso = wire_bit(sl_cur, sl_bit);
      end
      // spiClk rising: slave captures mosi
      if (!cs && !sck_p && spiClk) begin
        if (mo_bits == 0) begin
          first_rise = ncyc;
          if (rise_q.size() > 0) check("first_rise_cycle", ncyc, rise_q.pop_front());
          else                   check("unexpected_frame", 1, 0);
        end
`ifdef SPI_LSB_FIRST_EN
        mo_byte[3'(mo_bits)] = mosi;
`else
        mo_byte[3'(7 - mo_bits)] = mosi;
`endif
        mo_bits++;
        if (mo_bits == 8) begin
          mo_bits = 0;
          if (tx_q.size() > 0) check("mosi_byte", mo_byte, tx_q.pop_front());
          else                 check("unexpected_mosi_byte", 1, 0);
        end
      end
      if (rx_valid) begin
        if (exp_q.size() > 0) begin
          check("rx_byte", rx_byte, exp_q.pop_front());
          check("byte_time", ncyc - first_rise, 15 * CLK_DIV);
        end else begin
          check("unexpected_rx_valid", 1, 0);
        end
        last_valid = ncyc;
      end
      if (!cs_p && cs) begin
        check("cs_hold", ncyc - last_valid, CS_HOLD);
        check("cs_burst_done", sl_q.size(), 0);
        cs_rise = ncyc;
      end
      if (!rdy_p && ready && cs) check("gap_to_ready", ncyc - cs_rise, CS_HOLD);
      cs_p  = cs;
      sck_p = spiClk;
      rdy_p = ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k = 0;
    @(negedge sysClk);
    while (!ready && k < 2000) begin
      @(negedge sysClk);
      k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge sysClk);
    while ((busy || exp_q.size() > 0) && k < 3000) begin
      @(negedge sysClk);
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Issue an n-byte burst from b_tx/b_sl; cs stays low until the last byte
  task automatic run_burst(input int n);
    for (int i = 0; i < n; i++) sl_q.push_back(b_sl[i]);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      start   = 1'b1;
      tx_byte = b_tx[i];
      last    = (i == n - 1);
      exp_q.push_back(b_sl[i]);
      tx_q.push_back(b_tx[i]);
      rise_q.push_back(ncyc + 1 + ((i == 0) ? (CS_SETUP + CLK_DIV) : CLK_DIV));
      @(negedge sysClk);
      start   = 1'b0;
      tx_byte = 8'($urandom);
      last    = 1'($urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge sysClk);
    check("rst_cs", cs, 1);
    check("rst_spiclk", spiClk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    @(posedge sysClk); #2 reset = 1'b0;

    repeat (20) @(negedge sysClk);
    check("idle_cs", cs, 1);
    check("idle_spiclk", spiClk, 0);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);

    // Single byte
    b_tx[0] = 8'h41; b_sl[0] = 8'h79;
    run_burst(1);
    wait_idle();

    // Three-byte burst
    b_tx[0] = 8'h41; b_tx[1] = 8'h12; b_tx[2] = 8'h00;
    b_sl[0] = 8'h79; b_sl[1] = 8'h99; b_sl[2] = 8'hE4;
    run_burst(3);
    wait_idle();

    // start while not ready must be ignored
    b_tx[0] = 8'h5A; b_sl[0] = 8'hC3;
    run_burst(1);
    repeat (20) @(negedge sysClk);
    check("mid_byte_not_ready", ready, 0);
    start = 1'b1; tx_byte = 8'hFF; last = 1'b0;
    @(negedge sysClk);
    start = 1'b0;
    wait_idle();

    // Async reset in the middle of a frame, while spiClk is high
    b_tx[0] = 8'h3C; b_sl[0] = 8'h81;
    run_burst(1);
    repeat (32) @(negedge sysClk);
    check("pre_reset_spiclk", spiClk, 1);
    @(posedge sysClk); #2 reset = 1'b1;
    exp_q.delete(); tx_q.delete(); sl_q.delete(); rise_q.delete();
    #1;
    check("mid_rst_cs", cs, 1);
    check("mid_rst_spiclk", spiClk, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_ready", ready, 1);
    repeat (2) @(posedge sysClk);
    #2 reset = 1'b0;
    b_tx[0] = 8'hA5; b_sl[0] = 8'h5C;
    run_burst(1);
    wait_idle();

`ifdef SPI_LSB_FIRST_EN
    // LSB-first: mosi 1 then zeros; slave bitstream 1,0,... gives 0x01
    b_tx[0] = 8'h01; b_sl[0] = 8'h01;
    run_burst(1);
    wait_idle();
`endif

    // Random bursts
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b_tx[i] = 8'($urandom);
        b_sl[i] = 8'($urandom);
      end
      run_burst(n);
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge sysClk);
    end

    repeat (5) @(negedge sysClk);
    check("queues_drained", exp_q.size() + tx_q.size() + sl_q.size() + rise_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), 8-bit frames, MSB first by default.
- Counterpart to the SPI slave/MCP23S17 model: drives spiClk, cs (active-low) and mosi; samples miso.
- Supports multi-byte bursts with cs held low between bytes, as needed for MCP23S17 opcode/address/data sequences.
- Sits between a CPU-side peripheral register block and the external pins; everything runs in the sysClk domain.

Parameters:
CLK_DIV, 4, sysClk cycles per spiClk half-period; legal range >= 4.
CS_SETUP, 2, sysClk cycles from cs falling to the first spiClk low phase starting.
CS_HOLD, 2, sysClk cycles cs stays low after the final falling edge; also the minimum cs-high gap before the next frame.

Ports:
sysClk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request one byte transfer; accepted only when ready=1.
tx_byte  input  8  byte to send; sampled on the accepted start.
last  input  1  sampled with start; 1 ends the transaction (cs released) after this byte.
ready  output  1  block can accept start.
rx_byte  output  8  last received byte; holds until the next rx_valid.
rx_valid  output  1  one-cycle pulse when rx_byte updates.
busy  output  1  cs asserted or in the post-frame gap.
spiClk  output  1  SPI clock to the slave.
cs  output  1  chip select, active low.
mosi  output  1  master out.
miso  input  1  master in, asynchronous.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, cs=1, spiClk=0, mosi=0, rx_byte=0, rx_valid=0, busy=0, ready=1. All counters clear; the miso synchronizer clears to 0.
- miso passes through a 2-flop synchronizer. The sampled value is miso_sync.
- States and transitions:
  - IDLE: ready=1. An accepted start loads the shift register with tx_byte and latches last. Next cycle: cs=0, mosi=tx_byte[7], state=SETUP.
  - SETUP: counts CS_SETUP cycles, then goes to LO.
  - LO: spiClk=0 for CLK_DIV cycles, then HI (spiClk rises).
  - HI: spiClk=1 for CLK_DIV cycles. On the final HI cycle, shift miso_sync into the rx shift register; sampling at the end of the high phase absorbs the slave's synchronizer latency.
    - Then spiClk falls. If bits remain: mosi drives the next bit and state=LO.
    - After the 8th bit: rx_byte updates and rx_valid pulses on that cycle.
  - Byte boundary, latched last=0: state=WAIT. cs stays 0, spiClk stays 0, ready=1.
  - WAIT: an accepted start loads the new byte, sets mosi=tx_byte[7] the same cycle, and goes straight to LO. No SETUP.
  - Byte boundary, latched last=1: state=HOLD for CS_HOLD cycles (cs=0), then cs=1 and state=GAP.
  - GAP: CS_HOLD cycles with cs=1, then IDLE.
- ready=1 only in IDLE and WAIT. start while ready=0 is ignored; tx_byte/last changes outside acceptance have no effect.
- busy=1 in every state except IDLE.
- Byte time in sysClk cycles, from LO entry to rx_valid: 16*CLK_DIV.
- spiClk is glitch-free and driven from a register. mosi changes only on spiClk falling, or before the first rise.
- Reset mid-frame: lines return to reset values immediately. The partial byte is discarded with no rx_valid. The slave sees cs rise.

Optional Feature:
SPI_LSB_FIRST_EN.
- Defined: frames go LSB first. mosi starts with tx_byte[0]; the tx register shifts right; received bits fill from rx[7] downward, so the first received bit lands in rx_byte[0]. Timing is unchanged.
- Undefined: MSB first as described above.

Test Plan:
1. Reset release, then idle 20 cycles -> cs=1, spiClk=0, ready=1, busy=0, no rx_valid.
2. CLK_DIV=4, CS_SETUP=2, single byte: start with tx_byte=0x41, last=1; slave model returns 0x79.
   - mosi shows 0,1,0,0,0,0,0,1 on the 8 rising edges.
   - rx_valid pulses once with rx_byte=0x79, 64 cycles after LO entry.
   - cs rises CS_HOLD cycles later; ready=1 after the GAP.
3. Three-byte burst 0x41,0x12,0x00 with last=0,0,1; slave returns 0x79,0x99,0xE4.
   - cs stays low across all three bytes.
   - Three rx_valid pulses with those values.
   - No SETUP delay on bytes 2 and 3.
4. start pulsed mid-byte (ready=0) with tx_byte=0xFF -> ignored; the in-flight byte and the following cs timing are unchanged.
5. Async reset asserted during bit 4 -> cs=1, spiClk=0 in the same cycle; no rx_valid. Next start with 0xA5 completes normally.
6. SPI_LSB_FIRST_EN build: tx 0x01 -> mosi 1 on the first rising edge and 0 for the rest. Slave sends bitstream 1,0,0,0,0,0,0,0 -> rx_byte=0x01.
